// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Pops bytes from a 16x8 synchronous FIFO and transmits each
//                one as an 8N1 serial frame. A pop that collides with a FIFO
//                write is dropped by the FIFO, so the block notices and retries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic       fifo_wr,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int              CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             frame_done_q;

  logic             w_bit_end;
  logic             w_start_ok;

  assign w_bit_end  = (cnt_q == c_CNT_LAST);
  assign w_start_ok = enable && !fifo_empty;

  // Frame sequencer; tx/busy/frame_done are registered alongside the state so
  // they always match the state the FSM is in during the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (w_start_ok) begin
            state_q <= POP;
            busy_q  <= 1'b1;
          end
        end
        POP: begin
          // A write in the same cycle wins inside the FIFO, so the pop was
          // ignored; go back and issue it again rather than load stale data.
          if (fifo_wr || fifo_empty) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          shift_q <= fifo_dout;
          cnt_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (w_start_ok) begin
              state_q <= POP;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            // Raised one edge early so the pulse lands on the last stop cycle.
            frame_done_q <= (cnt_q == (c_CNT_LAST - 1'b1));
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd    = (state_q == POP);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Bench for fifo_uart_tx with a behavioural 16x8 FIFO
//                (write-over-read priority), a serial decoder and a byte
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_wr    (fifo_wr),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: a write in the same cycle as a pop wins, the pop is lost.
  logic [7:0] mem [16];
  logic [3:0] wptr = 4'd0;
  logic [3:0] rptr = 4'd0;
  int         fcnt = 0;
  logic       pop_ok;
  assign fifo_empty = (fcnt == 0);
  assign pop_ok     = (fifo_rd === 1'b1) && !fifo_wr && (fcnt > 0);

  always @(posedge clk) begin
    if (fifo_wr && fcnt < 16) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 4'd1;
    end
    if (pop_ok) begin
      fifo_dout <= mem[rptr];
      rptr      <= rptr + 4'd1;
    end
    fcnt <= fcnt + ((fifo_wr && fcnt < 16) ? 1 : 0) - (pop_ok ? 1 : 0);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd === 1'b1)    rd_cnt <= rd_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_wr = 1'b1;
    wr_data = b;
    tick();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy === 1'b0 && fifo_empty) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", (busy === 1'b0 && fifo_empty), 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_start_bit", (tx === 1'b0), 1);
  endtask

  // Monitor: decodes each serial frame, checks its shape and the frame_done
  // position, then pops the scoreboard. A reset during a frame abandons it.
  initial begin : monitor
    logic       smp [FRAME];
    logic       fdv [FRAME];
    logic [7:0] byte_v;
    logic       shape_ok;
    logic       fd_ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        starts.push_back(cyc);
        aborted = 1'b0;
        for (int s = 0; s < FRAME; s++) begin
          if (s > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          smp[s] = tx;
          fdv[s] = frame_done;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          fd_ok    = 1'b1;
          for (int b = 0; b < CPB; b++) begin
            if (smp[b] !== 1'b0) shape_ok = 1'b0;
            if (smp[9*CPB + b] !== 1'b1) shape_ok = 1'b0;
          end
          for (int i = 0; i < 8; i++) begin
            byte_v[i] = smp[CPB + CPB*i];
            for (int b = 1; b < CPB; b++)
              if (smp[CPB + CPB*i + b] !== byte_v[i]) shape_ok = 1'b0;
          end
          for (int s = 0; s < FRAME; s++)
            if (fdv[s] !== (s == FRAME - 1)) fd_ok = 1'b0;
          chk("frame_shape", shape_ok, 1);
          chk("frame_done_position", fd_ok, 1);
          chk("frame_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("rx_byte", byte_v, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int rd0;
    int fd0;
    int n0;
    int n;

    // Reset held three cycles with data waiting and enable high.
    rst     = 1'b1;
    enable  = 1'b1;
    fifo_wr = 1'b1;
    wr_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      fifo_wr = 1'b0;
      chk("rst_tx", tx, 1);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
    end
    rd0 = rd_cnt;
    exp_q.push_back(8'hA5);
    rst = 1'b0;
    tick();
    chk("first_rd_after_rst", fifo_rd, 1);
    chk("busy_in_pop", busy, 1);
    tick();
    chk("rd_one_cycle", fifo_rd, 0);
    chk("tx_high_in_load", tx, 1);
    tick();
    chk("tx_low_at_start", tx, 0);
    tick();
    wait_idle(200);
    chk("single_rd_count", rd_cnt - rd0, 1);
    chk("single_busy_end", busy, 0);

    // Back-to-back 0x00 then 0xFF.
    enable = 1'b0;
    push(8'h00);
    push(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    rd0 = rd_cnt;
    n0  = starts.size();
    enable = 1'b1;
    tick(); tick(); tick();
    wait_idle(300);
    chk("b2b_rd_count", rd_cnt - rd0, 2);
    chk("b2b_fifo_empty", fifo_empty, 1);
    chk("b2b_frames", starts.size() - n0, 2);
    if (starts.size() - n0 >= 2)
      chk("b2b_gap", starts[n0+1] - starts[n0], FRAME + 2);

    // Pop collides with a producer write.
    enable = 1'b0;
    push(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h3C);
    rd0 = rd_cnt;
    enable = 1'b1;
    n = 0;
    while (fifo_rd !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("collision_rd_seen", fifo_rd, 1);
    fifo_wr = 1'b1;
    wr_data = 8'h3C;
    tick();
    fifo_wr = 1'b0;
    chk("collision_back_idle", busy, 0);
    tick(); tick(); tick();
    wait_idle(300);
    chk("collision_rd_count", rd_cnt - rd0, 3);

    // Reset during data bit 3 of 0x5A.
    enable = 1'b0;
    push(8'h5A);
    fd0 = fd_cnt;
    enable = 1'b1;
    wait_tx_low(10);
    for (int i = 0; i < CPB + 3*CPB + 1; i++) tick();
    chk("bit3_of_5a", tx, 1);
    chk("busy_mid_frame", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < FRAME + 10; i++) tick();
    chk("midrst_no_frame_done", fd_cnt - fd0, 0);
    chk("midrst_still_idle", busy, 0);

    // enable falls during the first of three queued frames.
    enable = 1'b0;
    push(8'h81);
    push(8'h42);
    push(8'h24);
    exp_q.push_back(8'h81);
    rd0 = rd_cnt;
    enable = 1'b1;
    wait_tx_low(10);
    for (int i = 0; i < 2*CPB; i++) tick();
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("endrop_frame_ends", busy, 0);
    for (int i = 0; i < 30; i++) tick();
    chk("endrop_rd_count", rd_cnt - rd0, 1);
    chk("endrop_fifo_left", fcnt, 2);
    chk("endrop_busy", busy, 0);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h24);
    enable = 1'b1;
    tick(); tick(); tick();
    wait_idle(300);
    chk("endrop_drain_rd", rd_cnt - rd0, 3);

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
